// File: rtl/audio_proc_pkg.sv
// Shared encodings for the audio processing blocks.
package audio_proc_pkg;

    // Reduction mode applied across the taps of one bin
    typedef enum logic [1:0] {
        MODE_MEAN = 2'b00,
        MODE_SUM  = 2'b01,
        MODE_MAX  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // One-hot engine states
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_CFG    = 5'b00010,
        ST_ACCUM  = 5'b00100,
        ST_DIVIDE = 5'b01000,
        ST_EMIT   = 5'b10000
    } state_e;

    // Reserved mode behaves as mean
    function automatic logic mode_is_mean(input mode_e m);
        return (m != MODE_SUM) && (m != MODE_MAX);
    endfunction

endpackage

// File: rtl/mean_seq_divider.sv
// Sequential restoring divider: signed dividend / unsigned divisor,
// truncation toward zero, one quotient bit per cycle. The first step is
// taken on the start edge so done is high exactly ACC_WIDTH cycles later.
module mean_seq_divider #(
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned DIV_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [ACC_WIDTH-1:0] dividend,
    input  logic        [DIV_WIDTH-1:0] divisor,
    output logic signed [ACC_WIDTH-1:0] quotient_c,
    output logic                        done
);

    localparam int unsigned CNT_W = $clog2(ACC_WIDTH + 1);
    localparam logic [CNT_W-1:0] STEPS_LEFT = CNT_W'(ACC_WIDTH - 1);

    logic [DIV_WIDTH-1:0] rem_q, div_q, src_rem, src_div, nxt_rem;
    logic [ACC_WIDTH-1:0] quo_q, src_quo, nxt_quo, mag;
    logic [DIV_WIDTH:0]   shifted;
    logic                 ge;
    logic                 neg_q;
    logic [CNT_W-1:0]     cnt_q;

    // One restoring step, sourced from the inputs on start, else from state
    always_comb begin
        mag     = dividend[ACC_WIDTH-1] ? $unsigned(-dividend) : $unsigned(dividend);
        src_rem = start ? '0 : rem_q;
        src_quo = start ? mag : quo_q;
        src_div = start ? divisor : div_q;
        shifted = {src_rem, src_quo[ACC_WIDTH-1]};
        ge      = (shifted >= {1'b0, src_div});
        nxt_rem = ge ? DIV_WIDTH'(shifted - {1'b0, src_div}) : DIV_WIDTH'(shifted);
        nxt_quo = {src_quo[ACC_WIDTH-2:0], ge};
    end

    // Iteration state and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            div_q <= divisor;
            neg_q <= dividend[ACC_WIDTH-1];
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= STEPS_LEFT;
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q - CNT_W'(1);
            done  <= (cnt_q == CNT_W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

    // Restore the dividend sign on the magnitude quotient
    assign quotient_c = neg_q ? $signed(-quo_q) : $signed(quo_q);

endmodule

// File: rtl/band_mean_engine.sv
// Band reduction engine: for each of NUM_BINS bins, gathers one sample per
// loaded tap offset from external memory and emits their mean, saturated
// sum or maximum on a valid/ready result stream.
module band_mean_engine
    import audio_proc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned NUM_BINS   = 31,
    parameter int unsigned OFS_WIDTH  = 9,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_last,
    input  logic        [OFS_WIDTH-1:0]  cfg_data,
    input  logic        [1:0]            mode,
    input  logic                         start,
    output logic                         busy,
    output logic        [ADDR_WIDTH-1:0] mem_addr,
    output logic                         mem_rd_en,
    input  logic signed [DATA_WIDTH-1:0] mem_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_last,
    output logic                         err
);

    localparam int unsigned TBL_DEPTH = 2 ** OFS_WIDTH;
    localparam int unsigned CNT_WIDTH = OFS_WIDTH + 1;
    localparam int unsigned BIN_WIDTH = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [CNT_WIDTH-1:0] TBL_FULL = CNT_WIDTH'(TBL_DEPTH);
    localparam logic [BIN_WIDTH-1:0] LAST_BIN = BIN_WIDTH'(NUM_BINS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_e                        state_q, state_d;
    mode_e                         mode_q, mode_d;
    logic        [CNT_WIDTH-1:0]   n_q, n_d, k_q, k_d, r_q, r_d;
    logic        [BIN_WIDTH-1:0]   b_q, b_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, sample_ext, div_quo;
    logic signed [DATA_WIDTH-1:0]  res_d;
    logic                          err_d, olast_d, rd_en_d;
    logic                          cfg_accept, smp_vld_q, div_start, div_done;
    logic                          tbl_we;
    logic        [OFS_WIDTH-1:0]   tbl_waddr, tbl_raddr, tbl_q;
    logic        [OFS_WIDTH-1:0]   tbl_mem [TBL_DEPTH];

    // Clamp a wide result into the signed sample range
    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        k_d        = k_q;
        r_d        = r_q;
        b_d        = b_q;
        acc_d      = acc_q;
        err_d      = err;
        res_d      = o_data;
        olast_d    = o_last;
        tbl_we     = 1'b0;
        tbl_waddr  = n_q[OFS_WIDTH-1:0];
        div_start  = 1'b0;
        cfg_accept = cfg_valid && cfg_ready;
        sample_ext = ACC_WIDTH'(mem_data);

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_accept) begin
                    // A new load restarts the table at entry 0
                    err_d     = 1'b0;
                    tbl_we    = 1'b1;
                    tbl_waddr = '0;
                    n_d       = CNT_WIDTH'(1);
                    state_d   = cfg_last ? ST_IDLE : ST_CFG;
                end else if (start) begin
                    if (n_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = mode_e'(mode);
                        b_d     = '0;
                        k_d     = '0;
                        r_d     = '0;
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_CFG: begin
                if (cfg_accept) begin
                    if (n_q == TBL_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        tbl_we = 1'b1;
                        n_d    = n_q + CNT_WIDTH'(1);
                    end
                    if (cfg_last) state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (k_q < n_q) k_d = k_q + CNT_WIDTH'(1);
                if (smp_vld_q) begin
                    if (r_q == '0)
                        acc_d = sample_ext;
                    else if (mode_q == MODE_MAX)
                        acc_d = (sample_ext > acc_q) ? sample_ext : acc_q;
                    else
                        acc_d = acc_q + sample_ext;
                    r_d = r_q + CNT_WIDTH'(1);
                    if (r_q == n_q - CNT_WIDTH'(1)) begin
                        if (mode_is_mean(mode_q)) begin
                            div_start = 1'b1;
                            state_d   = ST_DIVIDE;
                        end else begin
                            res_d   = saturate(acc_d);
                            olast_d = (b_q == LAST_BIN);
                            state_d = ST_EMIT;
                        end
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    res_d   = saturate(div_quo);
                    olast_d = (b_q == LAST_BIN);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (o_ready) begin
                    if (b_q == LAST_BIN) begin
                        state_d = ST_IDLE;
                    end else begin
                        b_d     = b_q + BIN_WIDTH'(1);
                        k_d     = '0;
                        r_d     = '0;
                        state_d = ST_ACCUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_en_d   = (state_d == ST_ACCUM) && (k_d < n_q);
        tbl_raddr = k_d[OFS_WIDTH-1:0];
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_MEAN;
            n_q       <= '0;
            k_q       <= '0;
            r_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            mem_rd_en <= 1'b0;
            smp_vld_q <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            n_q       <= n_d;
            k_q       <= k_d;
            r_q       <= r_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            err       <= err_d;
            busy      <= (state_d == ST_ACCUM) || (state_d == ST_DIVIDE) || (state_d == ST_EMIT);
            cfg_ready <= (state_d == ST_IDLE) || (state_d == ST_CFG);
            mem_rd_en <= rd_en_d;
            smp_vld_q <= mem_rd_en;
            o_valid   <= (state_d == ST_EMIT);
            o_data    <= res_d;
            o_last    <= olast_d && (state_d == ST_EMIT);
        end
    end

    // Offset table storage (contents survive reset; n gates their use)
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_mem[tbl_waddr] <= cfg_data;
    end

    // Offset table synchronous read, prefetching the next tap index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbl_q <= '0;
        else        tbl_q <= tbl_mem[tbl_raddr];
    end

    assign mem_addr = ADDR_WIDTH'(32'(tbl_q) * 32'(NUM_BINS) + 32'(b_q));

    mean_seq_divider #(
        .ACC_WIDTH (ACC_WIDTH),
        .DIV_WIDTH (CNT_WIDTH)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (div_start),
        .dividend   (acc_d),
        .divisor    (n_q),
        .quotient_c (div_quo),
        .done       (div_done)
    );

endmodule

// File: doc/band_mean_engine.md
BAND_MEAN_ENGINE -- requirements
Module: band_mean_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9: signed sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14: sample-memory address width.
REQ-003 SHALL have parameter NUM_BINS, default 31: results per frame; also the offset stride.
REQ-004 SHALL have parameter OFS_WIDTH, default 9: tap offset width; table depth 2^OFS_WIDTH.
REQ-005 SHALL have parameter ACC_WIDTH, default 24: signed accumulator width.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports cfg_valid/cfg_ready/cfg_last, in/out/in, 1 each, and cfg_data, in, OFS_WIDTH: tap-offset load stream.
REQ-009 SHALL have port mode, input, 2: 00 mean, 01 saturated sum, 10 max, 11 reserved (treated as mean).
REQ-010 SHALL have ports start, input, 1 (frame request pulse) and busy, output, 1.
REQ-011 SHALL have ports mem_addr, out, ADDR_WIDTH; mem_rd_en, out, 1; mem_data, in signed, DATA_WIDTH: sync-read memory, data valid 1 cycle after mem_rd_en.
REQ-012 SHALL have ports o_valid, out, 1; o_ready, in, 1; o_data, out signed, DATA_WIDTH; o_last, out, 1: result stream.
REQ-013 SHALL have port err, output, 1: sticky, cleared by next accepted cfg beat after IDLE entry or by reset.

Function
REQ-014 States SHALL be IDLE, CFG, ACCUM, DIVIDE, EMIT; one-hot encoding.
REQ-015 cfg_ready SHALL be 1 in IDLE and CFG only; first accepted beat moves IDLE->CFG and resets tap count n to 0.
REQ-016 Each accepted beat SHALL write offset to table[n], n++; beats when n = 2^OFS_WIDTH SHALL be dropped and set err.
REQ-017 Beat with cfg_last SHALL end load, CFG->IDLE; table and n SHALL persist across frames until the next load.
REQ-018 start in IDLE with n>=1 SHALL latch mode, set bin b=0, busy=1, IDLE->ACCUM; start with n=0 SHALL set err and stay IDLE; start while busy SHALL be ignored.
REQ-019 ACCUM SHALL issue one read per cycle for taps k=0..n-1, mem_addr = table[k]*NUM_BINS + b (truncated to ADDR_WIDTH), mem_rd_en=1.
REQ-020 Returned samples SHALL be sign-extended and summed (mean/sum) or signed-maxed (max, init = first sample); ACCUM ends the cycle after the n-th sample arrives (n+1 cycles).
REQ-021 mean: ACCUM->DIVIDE; signed acc/n, truncation toward zero, exactly ACC_WIDTH cycles; sum/max: ACCUM->EMIT directly.
REQ-022 Result SHALL saturate to DATA_WIDTH signed range (sum mode: +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1)).
REQ-023 EMIT SHALL hold o_valid=1, o_data stable until o_ready; o_last=1 only for b=NUM_BINS-1.
REQ-024 On handshake: b<NUM_BINS-1 -> b++, EMIT->ACCUM; else EMIT->IDLE, busy=0 same edge.
REQ-025 Accumulator SHALL wrap if n*2^(DATA_WIDTH-1) exceeds ACC_WIDTH range; no detection required.
REQ-026 cfg_valid outside IDLE/CFG SHALL not be accepted (cfg_ready=0).

Reset
REQ-027 rst_n low SHALL force IDLE, n=0, b=0, err=0, busy=0, o_valid=0, o_last=0, o_data=0, mem_rd_en=0, mem_addr=0, cfg_ready=1 after release, accumulator and divider cleared.
REQ-028 Reset mid-frame SHALL abort with no further o_valid; table contents are don't-care, n=0 requires reload.

Structure
REQ-029 Mode encodings and state encodings SHALL live in shared package audio_proc_pkg.
REQ-030 Divider SHALL be sub-module mean_seq_divider (start/done, signed dividend ACC_WIDTH, unsigned divisor OFS_WIDTH+1).
REQ-031 Offset table SHALL be inferred single-port-write/sync-read RAM inside band_mean_engine.

Verification
REQ-032 Load offsets {0,1,2,3}, memory[a]=a mod 7 signed, mode=mean, o_ready=1 -> 31 results, bin b = trunc((sum of mem[31k+b], k=0..3)/4), o_last on 31st.
REQ-033 Offsets {0,1}, samples -255 and -2 at bin 0 -> mean o_data = -128 (toward zero); sum mode with 4 taps of -256 -> o_data = -256 saturated.
REQ-034 Mode=max, samples {-5,7,3} -> o_data=7; all {-9,-9,-9} -> -9.
REQ-035 o_ready toggled 1-in-3 -> o_data stable while stalled, exactly 31 handshakes, busy drops after last.
REQ-036 Load 513 beats (OFS_WIDTH=9) -> err=1, n=512; start with no load after reset -> err=1, busy stays 0.
REQ-037 rst_n asserted during bin 5 DIVIDE -> o_valid=0 immediately, IDLE after release, next start without reload sets err.
